// File: rtl/mux4_scan_if.sv
// mux4_scan_if: request, mux sample, select and captured-bit bundle of the
// mux4_scan_ctrl sequencer. The master side is the sequencer; the slave side
// is the requesters / mux / consumer environment around it.
interface mux4_scan_if;
  logic [3:0] req;
  logic       w_in;
  logic       sel_s;
  logic       sel_t;
  logic       busy;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_bit;
  logic [1:0] dout_ch;
  logic       err;

  modport master (
    input  req, w_in, dout_ready,
    output sel_s, sel_t, busy, dout_valid, dout_bit, dout_ch, err
  );

  modport slave (
    output req, w_in, dout_ready,
    input  sel_s, sel_t, busy, dout_valid, dout_bit, dout_ch, err
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: round-robin sequencer for a four-input tristate mux.
// Grants one requesting channel, drives its index onto {sel_t, sel_s}, waits
// SETTLE_CYCLES edges for the mux output to settle, captures w_in and offers
// the bit with its channel number on a valid/ready port.
// Optional feature: define MUX4_SCAN_DOUBLE_SAMPLE_EN to sample w_in a second
// time one edge later and flag a mismatch on err.
module mux4_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mux4_scan_if.master bus
);

  // A settle window of 0 would never reach the sample point; run it as 1.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES < 1) ? 4'd1 : 4'(SETTLE_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
  localparam logic [1:0] CHECK  = 2'd2;
`endif
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] last_ch;
  logic [1:0] sel;
  logic [1:0] dout_ch;
  logic       dout_bit;
  logic       dout_valid;
  logic       err;

  logic [1:0] grant;
  logic       grant_vld;
  logic [1:0] scan_idx;

  // Round-robin pick: first requesting channel scanning upward from last_ch+1.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_ch + 2'(i);
      if (!grant_vld && bus.req[scan_idx]) begin
        grant     = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Sequencer: grant, settle countdown, capture (and re-check), hold for handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_ch    <= 2'd3;
      sel        <= '0;
      dout_ch    <= '0;
      dout_bit   <= 1'b0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          if (grant_vld) begin
            sel     <= grant;
            dout_ch <= grant;
            last_ch <= grant;
            cnt     <= SETTLE_LOAD;
            err     <= 1'b0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd1) begin
            dout_bit <= bus.w_in;
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
            state    <= CHECK;
`else
            dout_valid <= 1'b1;
            state      <= HOLD;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
        CHECK: begin
          // The second sample wins; err records whether the first one agreed.
          dout_bit   <= bus.w_in;
          err        <= dout_bit ^ bus.w_in;
          dout_valid <= 1'b1;
          state      <= HOLD;
        end
`endif
        HOLD: begin
          if (bus.dout_ready) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel_s      = sel[0];
  assign bus.sel_t      = sel[1];
  assign bus.busy       = (state != IDLE);
  assign bus.dout_valid = dout_valid;
  assign bus.dout_bit   = dout_bit;
  assign bus.dout_ch    = dout_ch;
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
  assign bus.err        = err;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: self-checking bench for mux4_scan_ctrl. Inputs change and
// outputs are sampled on the falling clock edge. Expected grants come from a
// round-robin model over the request vector; expected timing from the settle
// window length.
module tb_mux4_scan_ctrl;

  localparam int SETTLE = 2;
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
  localparam int LAT = SETTLE + 1;
`else
  localparam int LAT = SETTLE;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_scan_if bif ();

  mux4_scan_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks  = 0;
  int errors  = 0;
  int last_ch = 3;

  // Round-robin reference: first set request after the last granted channel.
  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // Waits (bounded) for dout_valid; cycles = falling edges waited.
  task automatic wait_valid(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < 64 && !ok) begin
      @(negedge clk);
      cycles++;
      if (bif.dout_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic handshake;
    bif.dout_ready = 1'b1;
    @(negedge clk);
    bif.dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    int exp; int cyc; bit ok; logic [1:0] e2;
    rst_n = 1'b0;
    bif.req = 4'hF;
    bif.w_in = 1'b1;
    bif.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bif.sel_t, bif.sel_s, bif.busy, bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {bif.sel_t, bif.sel_s, bif.busy, bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err});
    end
    rst_n = 1'b1;
    exp = rr_pick(3, 4'hF);
    e2 = 2'(exp);
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.sel_t, bif.sel_s, bif.dout_ch} !== {1'b1, e2, e2}) begin
      errors++;
      $display("FAIL reset_first_grant: got busy/sel/ch %b want %b",
               {bif.busy, bif.sel_t, bif.sel_s, bif.dout_ch}, {1'b1, e2, e2});
    end
    last_ch = exp;
    bif.req = 4'h0;
    wait_valid(cyc, ok);
    checks++;
    if (!ok || bif.dout_ch !== e2) begin
      errors++;
      $display("FAIL reset_first_txn: valid=%0b ch=%0d want valid=1 ch=%0d", ok, bif.dout_ch, e2);
    end
    handshake();
  endtask

  task automatic test_single;
    int exp; logic [1:0] e2;
    bif.req = 4'b0100;
    bif.w_in = 1'b0;
    exp = rr_pick(last_ch, 4'b0100);
    e2 = 2'(exp);
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.sel_t, bif.sel_s} !== {1'b1, e2}) begin
      errors++;
      $display("FAIL single_sel: got busy/t/s %b want %b", {bif.busy, bif.sel_t, bif.sel_s}, {1'b1, e2});
    end
    bif.req = 4'h0;
    bif.w_in = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      checks++;
      if (bif.dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early_valid: edge %0d valid=%b want 0", k, bif.dout_valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err} !== {1'b1, 1'b1, e2, 1'b0}) begin
      errors++;
      $display("FAIL single_capture: got valid/bit/ch/err %b want %b",
               {bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err}, {1'b1, 1'b1, e2, 1'b0});
    end
    last_ch = exp;
    handshake();
    checks++;
    if ({bif.dout_valid, bif.busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_release: got valid/busy %b want 00", {bif.dout_valid, bif.busy});
    end
  endtask

  task automatic test_round_robin;
    int exp; int grants; int cyc; int t_prev; logic prev_busy;
    grants = 0; cyc = 0; t_prev = 0;
    prev_busy = bif.busy;
    bif.dout_ready = 1'b1;
    bif.req = 4'hF;
    while (grants < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bif.busy === 1'b1 && prev_busy === 1'b0) begin
        exp = rr_pick(last_ch, 4'hF);
        checks++;
        if ({bif.sel_t, bif.sel_s} !== 2'(exp)) begin
          errors++;
          $display("FAIL rr_order: grant %0d got ch %0d want %0d", grants, {bif.sel_t, bif.sel_s}, exp);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - t_prev != LAT + 2) begin
            errors++;
            $display("FAIL rr_spacing: grant %0d got %0d cycles want %0d", grants, cyc - t_prev, LAT + 2);
          end
        end
        t_prev = cyc;
        last_ch = exp;
        grants++;
      end
      prev_busy = bif.busy;
    end
    bif.req = 4'h0;
    checks++;
    if (grants != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 5", grants);
    end
    cyc = 0;
    while (bif.busy !== 1'b0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    bif.dout_ready = 1'b0;
    checks++;
    if ({bif.busy, bif.dout_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rr_drain: got busy/valid %b want 00", {bif.busy, bif.dout_valid});
    end
  endtask

  task automatic test_backpressure;
    int exp; int cyc; bit ok; logic [1:0] e2; logic wexp;
    wexp = 1'($urandom_range(0, 1));
    bif.w_in = wexp;
    bif.req = 4'hF;
    exp = rr_pick(last_ch, 4'hF);
    e2 = 2'(exp);
    @(negedge clk);
    bif.req = 4'h0;
    wait_valid(cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid_timeout: valid=0 want 1");
    end
    for (int k = 0; k < 10; k++) begin
      bif.w_in = 1'($urandom_range(0, 1));
      bif.req = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.sel_t, bif.sel_s, bif.busy} !== {1'b1, wexp, e2, e2, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got %b want %b", k,
                 {bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.sel_t, bif.sel_s, bif.busy},
                 {1'b1, wexp, e2, e2, 1'b1});
      end
    end
    last_ch = exp;
    bif.req = 4'h0;
    handshake();
    checks++;
    if (bif.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b want 0", bif.dout_valid);
    end
  endtask

  task automatic test_reset_mid;
    int exp; int cyc; bit ok; logic [1:0] e2;
    bif.req = 4'b0110;
    @(negedge clk);
    bif.req = 4'hF;
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.dout_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_settle_state: got busy/valid %b want 10", {bif.busy, bif.dout_valid});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.sel_t, bif.sel_s, bif.busy, bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b want 00000000",
               {bif.sel_t, bif.sel_s, bif.busy, bif.dout_valid, bif.dout_bit, bif.dout_ch, bif.err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_ch = 3;
    exp = rr_pick(last_ch, 4'hF);
    e2 = 2'(exp);
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.sel_t, bif.sel_s, bif.dout_ch} !== {1'b1, e2, e2}) begin
      errors++;
      $display("FAIL mid_regrant: got busy/sel/ch %b want %b",
               {bif.busy, bif.sel_t, bif.sel_s, bif.dout_ch}, {1'b1, e2, e2});
    end
    last_ch = exp;
    bif.req = 4'h0;
    wait_valid(cyc, ok);
    checks++;
    if (!ok || cyc != LAT) begin
      errors++;
      $display("FAIL mid_regrant_latency: valid=%0b after %0d edges want 1 after %0d", ok, cyc, LAT);
    end
    handshake();
  endtask

  task automatic test_random;
    int exp; int cyc; bit ok; logic [3:0] r; logic wv; logic [1:0] e2;
    for (int n = 0; n < 20; n++) begin
      r = 4'($urandom_range(1, 15));
      wv = 1'($urandom_range(0, 1));
      bif.req = r;
      exp = rr_pick(last_ch, r);
      e2 = 2'(exp);
      @(negedge clk);
      checks++;
      if ({bif.busy, bif.sel_t, bif.sel_s} !== {1'b1, e2}) begin
        errors++;
        $display("FAIL rand_grant: txn %0d req=%b got busy/sel %b want %b", n, r,
                 {bif.busy, bif.sel_t, bif.sel_s}, {1'b1, e2});
      end
      bif.req = 4'($urandom);
      bif.w_in = wv;
      wait_valid(cyc, ok);
      checks++;
      if (!ok || cyc != LAT || {bif.dout_bit, bif.dout_ch, bif.err} !== {wv, e2, 1'b0}) begin
        errors++;
        $display("FAIL rand_capture: txn %0d valid=%0b edges=%0d bit/ch/err=%b want 1 %0d %b",
                 n, ok, cyc, {bif.dout_bit, bif.dout_ch, bif.err}, LAT, {wv, e2, 1'b0});
      end
      last_ch = exp;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (bif.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_hold: txn %0d got valid=%b want 1", n, bif.dout_valid);
      end
      handshake();
    end
    bif.req = 4'h0;
    @(negedge clk);
  endtask

`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
  task automatic test_double_sample;
    int exp; int cyc; bit ok;
    bif.req = 4'b0001;
    bif.w_in = 1'b0;
    exp = rr_pick(last_ch, 4'b0001);
    @(negedge clk);
    bif.req = 4'h0;
    repeat (SETTLE) @(negedge clk);
    checks++;
    if (bif.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ds_early_valid: got valid=%b want 0", bif.dout_valid);
    end
    bif.w_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.dout_valid, bif.err, bif.dout_bit} !== 3'b111) begin
      errors++;
      $display("FAIL ds_mismatch: got valid/err/bit %b want 111", {bif.dout_valid, bif.err, bif.dout_bit});
    end
    last_ch = exp;
    handshake();
    bif.req = 4'hF;
    exp = rr_pick(last_ch, 4'hF);
    @(negedge clk);
    bif.req = 4'h0;
    checks++;
    if ({bif.busy, bif.err} !== 2'b10) begin
      errors++;
      $display("FAIL ds_err_clear: got busy/err %b want 10", {bif.busy, bif.err});
    end
    wait_valid(cyc, ok);
    checks++;
    if (!ok || cyc != LAT || {bif.err, bif.dout_bit} !== 2'b01) begin
      errors++;
      $display("FAIL ds_stable: valid=%0b edges=%0d err/bit=%b want 1 %0d 01", ok, cyc, {bif.err, bif.dout_bit}, LAT);
    end
    last_ch = exp;
    handshake();
  endtask
`endif

  initial begin
    bif.req = 4'h0;
    bif.w_in = 1'b0;
    bif.dout_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MUX4_SCAN_DOUBLE_SAMPLE_EN
    test_double_sample();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
